// File: rtl/ps2_line_builder.sv
// ps2_line_builder: gathers decoded PS/2 ASCII keys into an editable line buffer
// and commits the line as one packed word with a single-cycle ready pulse.
// Optional feature macro: PS2_LINE_CURSOR_EN overlays a '_' cursor glyph on
// live_line at the current insertion point. The glyph is display-only.
module ps2_line_builder #(
  parameter int            LINE_CHARS = 32,
  parameter int            CHAR_W     = 8,
  parameter logic [7:0]    ENTER_CODE = 8'h0D,
  parameter logic [7:0]    BS_CODE    = 8'h08,
  localparam int           LEN_W      = $clog2(LINE_CHARS) + 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         key_valid,
  input  logic [7:0]                   key_ascii,
  output logic [LINE_CHARS*CHAR_W-1:0] live_line,
  output logic [LINE_CHARS*CHAR_W-1:0] line_content,
  output logic                         line_ready,
  output logic [LEN_W-1:0]             line_length,
  output logic                         overflow,
  output logic                         key_dropped
);

  localparam int IDX_W = $clog2(LINE_CHARS);
  localparam logic [CHAR_W-1:0] CURSOR_GLYPH = CHAR_W'(8'h5F);

  typedef enum logic {S_EDIT, S_COMMIT} state_t;

  // line_buf[i] is character i; output packing puts char 0 in the top byte
  typedef logic [LINE_CHARS-1:0][CHAR_W-1:0] line_t;

  state_t           state_q, state_n;
  line_t            line_buf_q, line_buf_n;
  line_t            content_q, content_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic             ready_q, ready_n;
  logic             ovf_q, ovf_n;
  logic             drop_q, drop_n;

  logic             is_print, full, empty;
  logic [IDX_W-1:0] wr_idx, bs_idx;

  assign is_print = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);
  assign full     = (len_q == LEN_W'(LINE_CHARS));
  assign empty    = (len_q == '0);
  // only used when not full / not empty, so the truncation never aliases
  assign wr_idx   = IDX_W'(len_q);
  assign bs_idx   = IDX_W'(len_q - LEN_W'(1));

  // state and datapath registers; reset drops any pending commit pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_EDIT;
      line_buf_q <= '0;
      content_q  <= '0;
      len_q      <= '0;
      ready_q    <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      line_buf_q <= line_buf_n;
      content_q  <= content_n;
      len_q      <= len_n;
      ready_q    <= ready_n;
      ovf_q      <= ovf_n;
      drop_q     <= drop_n;
    end
  end

  // next-state: edit keys in S_EDIT, one dead cycle in S_COMMIT
  always_comb begin
    state_n    = state_q;
    line_buf_n = line_buf_q;
    content_n  = content_q;
    len_n      = len_q;
    ready_n    = 1'b0;
    ovf_n      = ovf_q;
    drop_n     = drop_q;
    case (state_q)
      S_EDIT: begin
        if (key_valid) begin
          if (is_print) begin
            if (!full) begin
              line_buf_n[wr_idx] = CHAR_W'(key_ascii);
              len_n              = len_q + LEN_W'(1);
            end else begin
              ovf_n = 1'b1;
            end
          end else if (key_ascii == BS_CODE) begin
            if (!empty) begin
              line_buf_n[bs_idx] = '0;
              len_n              = len_q - LEN_W'(1);
            end
          end else if (key_ascii == ENTER_CODE) begin
            // an empty line never commits, so line_content keeps the last line
            if (!empty) begin
              content_n  = line_buf_q;
              ready_n    = 1'b1;
              line_buf_n = '0;
              len_n      = '0;
              ovf_n      = 1'b0;
              state_n    = S_COMMIT;
            end
          end
        end
      end
      S_COMMIT: begin
        state_n = S_EDIT;
        if (key_valid) drop_n = 1'b1;
      end
      default: state_n = S_EDIT;
    endcase
  end

  // pack per-character lanes into the flat output words
  for (genvar i = 0; i < LINE_CHARS; i++) begin : g_lane
    assign line_content[(LINE_CHARS-1-i)*CHAR_W +: CHAR_W] = content_q[i];
`ifdef PS2_LINE_CURSOR_EN
    // stored byte at index len_q is always zero, so the glyph hides nothing
    assign live_line[(LINE_CHARS-1-i)*CHAR_W +: CHAR_W] =
      (len_q == LEN_W'(i)) ? CURSOR_GLYPH : line_buf_q[i];
`else
    assign live_line[(LINE_CHARS-1-i)*CHAR_W +: CHAR_W] = line_buf_q[i];
`endif
  end

  assign line_ready  = ready_q;
  assign line_length = len_q;
  assign overflow    = ovf_q;
  assign key_dropped = drop_q;

endmodule

// File: tb/tb_ps2_line_builder.sv
// Self-checking bench for ps2_line_builder: directed key sequences, a behavioural
// line model, and a scoreboard of committed lines popped on each line_ready.
module tb_ps2_line_builder;

`ifdef PS2_LINE_CURSOR_EN
  localparam bit CUR = 1'b1;
`else
  localparam bit CUR = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         key_valid = 1'b0;
  logic [7:0]   key_ascii = 8'h00;
  logic [255:0] live_line, line_content;
  logic         line_ready, overflow, key_dropped;
  logic [5:0]   line_length;

  ps2_line_builder dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_ascii(key_ascii),
    .live_line(live_line), .line_content(line_content), .line_ready(line_ready),
    .line_length(line_length), .overflow(overflow), .key_dropped(key_dropped)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model
  logic [7:0]   m_buf [32];
  int           m_len;
  bit           m_ovf, m_drop, m_commit, m_rdy;
  logic [255:0] m_content;
  logic [255:0] sb [$];
  logic [255:0] saved;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pack_model(input bit cursor);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[255-8*i -: 8] = m_buf[i];
    if (cursor && m_len < 32) r[255-8*m_len -: 8] = 8'h5F;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h00;
    m_len = 0; m_ovf = 0; m_drop = 0; m_commit = 0; m_rdy = 0;
    m_content = '0;
    sb.delete();
  endtask

  task automatic check_all();
    logic [255:0] exp;
    chk("line_ready", line_ready, m_rdy);
    if (line_ready === 1'b1) begin
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      chk("sb_line_content", line_content, exp);
    end
    chk("line_content", line_content, m_content);
    chk("live_line", live_line, pack_model(CUR));
    chk("line_length", line_length, m_len);
    chk("overflow", overflow, m_ovf);
    chk("key_dropped", key_dropped, m_drop);
  endtask

  // one clock: drive (optional) key, advance model, check outputs #1 after edge
  task automatic cyc(input bit v, input logic [7:0] k);
    key_valid = v; key_ascii = k;
    @(posedge clock); #1;
    key_valid = 1'b0; key_ascii = 8'h00;
    m_rdy = 0;
    if (m_commit) begin
      m_commit = 0;
      if (v) m_drop = 1;
    end else if (v) begin
      if (k >= 8'h20 && k <= 8'h7E) begin
        if (m_len < 32) begin m_buf[m_len] = k; m_len++; end
        else m_ovf = 1;
      end else if (k == 8'h08) begin
        if (m_len > 0) begin m_len--; m_buf[m_len] = 8'h00; end
      end else if (k == 8'h0D && m_len > 0) begin
        m_content = pack_model(1'b0);
        sb.push_back(m_content);
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h00;
        m_len = 0; m_ovf = 0; m_commit = 1; m_rdy = 1;
      end
    end
    check_all();
  endtask

  task automatic key(input logic [7:0] k);
    cyc(1'b1, k);
  endtask

  // async reset asserted mid-cycle; outputs must clear without a clock edge
  task automatic mid_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #3 reset = 1'b0;
    cyc(1'b0, 8'h00);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    reset = 1'b0;
    cyc(1'b0, 8'h00);

    // 1: RUN + Enter
    key("R"); key("U"); key("N");
    key(8'h0D);
    chk("t1_ready", line_ready, 1'b1);
    chk("t1_content", line_content, {24'h52554E, 232'h0});
    chk("t1_len", line_length, 6'd0);
    cyc(1'b0, 8'h00);
    chk("t1_pulse_one_cycle", line_ready, 1'b0);

    // 2: edit with backspace, then BS at length 0
    key("A"); key("B"); key(8'h08); key("C");
    key(8'h0D);
    chk("t2_content", line_content, {16'h4143, 240'h0});
    cyc(1'b0, 8'h00);
    key(8'h08);
    chk("t2_bs_floor", line_length, 6'd0);
    key(8'h01);

    // 3: fill past capacity
    for (int i = 0; i < 33; i++) key("X");
    chk("t3_len", line_length, 6'd32);
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_live", live_line, {32{8'h58}});
    key(8'h0D);
    chk("t3_ovf_clr", overflow, 1'b0);
    chk("t3_content", line_content, {32{8'h58}});
    cyc(1'b0, 8'h00);

    // 4: empty Enter, then key during commit cycle
    saved = line_content;
    key(8'h0D);
    chk("t4_no_pulse", line_ready, 1'b0);
    chk("t4_hold", line_content, saved);
    key("Q"); key(8'h0D); key("Z");
    chk("t4_dropped", key_dropped, 1'b1);
    chk("t4_len", line_length, 6'd0);
    cyc(1'b0, 8'h00);

    // 5: reset during S_COMMIT and mid-line
    key("A"); key(8'h0D);
    mid_reset();
    chk("t5_ready_clr", line_ready, 1'b0);
    key(8'h0D);
    chk("t5_no_pulse_a", line_ready, 1'b0);
    key("B"); key("C");
    mid_reset();
    chk("t5_live_clr", live_line[255:232], 24'h0);
    key(8'h0D);
    chk("t5_no_pulse_b", line_ready, 1'b0);

    // 6: cursor overlay
    key("H"); key("I");
    chk("t6_live_b2", live_line[239:232], CUR ? 8'h5F : 8'h00);
    key(8'h0D);
    chk("t6_content", line_content, {16'h4849, 240'h0});
    chk("t6_content_b2", line_content[239:232], 8'h00);
    cyc(1'b0, 8'h00);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
